// File: rtl/hw_pkg.sv
// Shared types and defaults for the hidden-neuron sequencer and its fetch stage.
package hw_pkg;

    localparam int DEF_N_INPUTS = 16;
    localparam int DEF_W_WIDTH  = 8;
    localparam int SUM_WIDTH    = 32;

    typedef logic [SUM_WIDTH-1:0] hw_sum_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_CAPTURE,
        ST_HOLD
    } hw_seq_state_t;

endpackage

// File: rtl/hw_fetch_stage.sv
// Aligns the weight-memory read with its returning data: delays the read enable
// and address by one cycle and drives the accumulator strobe, weight and input bit.
module hw_fetch_stage
    import hw_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int W_WIDTH  = DEF_W_WIDTH,
    parameter int AW       = $clog2(N_INPUTS)
) (
    input  logic                Clk,
    input  logic                RST,
    input  logic                Flush,
    input  logic                RdEn,
    input  logic [AW-1:0]       Idx,
    input  logic [W_WIDTH-1:0]  WData,
    input  logic [N_INPUTS-1:0] XVal,
    output logic                Get,
    output logic [W_WIDTH-1:0]  W,
    output logic                X
);

    logic          enD;
    logic [AW-1:0] idxD;

    // A flush drops any read in flight so an aborted run cannot strobe the accumulator.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            enD  <= 1'b0;
            idxD <= '0;
        end else if (Flush) begin
            enD  <= 1'b0;
            idxD <= '0;
        end else begin
            enD  <= RdEn;
            idxD <= Idx;
        end
    end

    assign Get = enD;
    assign W   = enD ? WData : '0;
    assign X   = enD & XVal[idxD];

endmodule

// File: rtl/hw_sequencer.sv
// Sequences one neuron evaluation: clear the accumulator, stream N weights into it,
// then capture the final sum and hold it behind a valid/ready handshake.
module hw_sequencer
    import hw_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int W_WIDTH  = DEF_W_WIDTH,
    parameter int AW       = $clog2(N_INPUTS)
) (
    input  logic                Clk,
    input  logic                RST,
    input  logic                Start,
    input  logic                Abort,
    input  logic [N_INPUTS-1:0] XVec,
    output logic [AW-1:0]       WAddr,
    output logic                WRdEn,
    input  logic [W_WIDTH-1:0]  WData,
    output logic [W_WIDTH-1:0]  W,
    output logic                X,
    output logic                ComputeH,
    output logic                Get,
    output logic                RstSum,
    input  hw_sum_t             Z,
    output hw_sum_t             Result,
    output logic                ResultValid,
    input  logic                ResultReady,
    output logic                Busy,
    output logic                Done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_INPUTS - 1);

    hw_seq_state_t       state, nextState;
    logic [AW-1:0]       idx;
    logic [N_INPUTS-1:0] xReg;
    hw_sum_t             resultReg;
    logic                resultValidReg;
    logic                doneReg;
    logic                abortClr;
    logic                abortNow;
    logic                fetchGet;

    assign abortNow = Abort && (state inside {ST_CLEAR, ST_RUN, ST_DRAIN, ST_CAPTURE});

    always_comb begin
        nextState = state;
        WRdEn     = 1'b0;
        unique case (state)
            ST_IDLE:    if (Start) nextState = ST_CLEAR;
            ST_CLEAR:   nextState = ST_RUN;
            ST_RUN: begin
                WRdEn = !abortNow;
                if (idx == LAST_IDX) nextState = ST_DRAIN;
            end
            ST_DRAIN:   nextState = ST_CAPTURE;
            ST_CAPTURE: nextState = ST_HOLD;
            ST_HOLD:    if (resultValidReg && ResultReady) nextState = ST_IDLE;
            default:    nextState = ST_IDLE;
        endcase
        if (abortNow) nextState = ST_IDLE;
    end

    // Abort leaves a one-cycle accumulator clear behind it (abortClr) instead of a result.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state          <= ST_IDLE;
            idx            <= '0;
            xReg           <= '0;
            resultReg      <= '0;
            resultValidReg <= 1'b0;
            doneReg        <= 1'b0;
            abortClr       <= 1'b0;
        end else begin
            state    <= nextState;
            abortClr <= abortNow;
            doneReg  <= 1'b0;
            if (state == ST_IDLE && Start) begin
                xReg <= XVec;
            end
            if (state == ST_CLEAR || abortNow) begin
                idx <= '0;
            end else if (state == ST_RUN && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
            if (state == ST_CAPTURE && !abortNow) begin
                resultReg      <= Z;
                resultValidReg <= 1'b1;
                doneReg        <= 1'b1;
            end else if (state == ST_HOLD && resultValidReg && ResultReady) begin
                resultValidReg <= 1'b0;
            end
        end
    end

    hw_fetch_stage #(
        .N_INPUTS (N_INPUTS),
        .W_WIDTH  (W_WIDTH),
        .AW       (AW)
    ) uFetch (
        .Clk   (Clk),
        .RST   (RST),
        .Flush (abortNow),
        .RdEn  (WRdEn),
        .Idx   (idx),
        .WData (WData),
        .XVal  (xReg),
        .Get   (fetchGet),
        .W     (W),
        .X     (X)
    );

    assign WAddr       = idx;
    assign Get         = fetchGet;
    assign ComputeH    = fetchGet;
    assign RstSum      = (state == ST_CLEAR) || abortClr;
    assign Result      = resultReg;
    assign ResultValid = resultValidReg;
    assign Busy        = (state != ST_IDLE);
    assign Done        = doneReg;

endmodule

// File: tb/tb_hw_sequencer.sv
// Directed bench for hw_sequencer with N=4, a behavioural accumulator and a
// synchronous weight memory; cycle numbers count from the cycle Start is sampled.
module tb_hw_sequencer;
    import hw_pkg::*;

    localparam int N  = 4;
    localparam int WW = 8;
    localparam int AW = 2;

    logic          Clk, RST, Start, Abort, ResultReady;
    logic [N-1:0]  XVec;
    logic [AW-1:0] WAddr;
    logic          WRdEn, X, ComputeH, Get, RstSum, ResultValid, Busy, Done;
    logic [WW-1:0] WData, W;
    hw_sum_t       Z, Result;
    logic [WW-1:0] mem [N];

    int checks = 0;
    int errors = 0;

    hw_sequencer #(.N_INPUTS(N), .W_WIDTH(WW), .AW(AW)) dut (
        .Clk(Clk), .RST(RST), .Start(Start), .Abort(Abort), .XVec(XVec),
        .WAddr(WAddr), .WRdEn(WRdEn), .WData(WData), .W(W), .X(X),
        .ComputeH(ComputeH), .Get(Get), .RstSum(RstSum), .Z(Z),
        .Result(Result), .ResultValid(ResultValid), .ResultReady(ResultReady),
        .Busy(Busy), .Done(Done)
    );

    // Clock generation.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Accumulator model: Get has priority over RstSum, signed 8-bit weight times 1-bit input.
    always @(posedge Clk or posedge RST) begin
        if (RST)         Z <= '0;
        else if (Get)    Z <= Z + (X ? {{24{W[7]}}, W} : 32'd0);
        else if (RstSum) Z <= '0;
    end

    // Synchronous weight memory with one-cycle read latency.
    always @(posedge Clk) begin
        if (WRdEn) WData <= mem[WAddr];
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic loadWeights(input logic [7:0] w0, w1, w2, w3);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    endtask

    // Reset state: every output low while RST is held.
    task automatic test_reset();
        RST = 1'b1; Start = 1'b0; Abort = 1'b0; ResultReady = 1'b0; XVec = '0;
        loadWeights(8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        checks++;
        if ({WAddr, WRdEn, W, X, ComputeH, Get, RstSum, Result, ResultValid, Busy, Done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got Busy=%b RstSum=%b Get=%b ResultValid=%b Result=%h expected all 0",
                     Busy, RstSum, Get, ResultValid, Result);
        end
        RST = 1'b0;
        tick();
    endtask

    // Nominal run: weights {3,5,7,2}, XVec 1011 -> 10, with exact cycle timing.
    task automatic test_basic();
        logic [15:0] getMask, rstMask;
        int validCyc, doneCnt, doneCyc;
        logic overlap, strobeDiff, validAt9;
        hw_sum_t res8;
        getMask = '0; rstMask = '0; validCyc = -1; doneCnt = 0; doneCyc = -1;
        overlap = 1'b0; strobeDiff = 1'b0; validAt9 = 1'b1; res8 = '1;
        loadWeights(8'd3, 8'd5, 8'd7, 8'd2);
        XVec = 4'b1011; ResultReady = 1'b1; Start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin Start = 1'b0; XVec = 4'b0000; end
            getMask[c] = Get;
            rstMask[c] = RstSum;
            if (Done) begin doneCnt++; doneCyc = c; end
            if (ResultValid && validCyc < 0) validCyc = c;
            if (RstSum && Get) overlap = 1'b1;
            if (ComputeH !== Get) strobeDiff = 1'b1;
            if (c == 8) res8 = Result;
            if (c == 9) validAt9 = ResultValid;
        end
        checks++;
        if (rstMask !== 16'h0002) begin
            errors++; $display("[TB] FAIL basic_rstsum_cycles got %h expected 0002", rstMask);
        end
        checks++;
        if (getMask !== 16'h0078) begin
            errors++; $display("[TB] FAIL basic_get_cycles got %h expected 0078", getMask);
        end
        checks++;
        if (validCyc != 8) begin
            errors++; $display("[TB] FAIL basic_valid_cycle got %0d expected 8", validCyc);
        end
        checks++;
        if (res8 !== 32'd10) begin
            errors++; $display("[TB] FAIL basic_result got %0d expected 10", res8);
        end
        checks++;
        if (doneCnt != 1 || doneCyc != 8) begin
            errors++; $display("[TB] FAIL basic_done got count=%0d cycle=%0d expected count=1 cycle=8", doneCnt, doneCyc);
        end
        checks++;
        if (overlap !== 1'b0 || strobeDiff !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_strobes got overlap=%b computeh_diff=%b expected 0 0", overlap, strobeDiff);
        end
        checks++;
        if (validAt9 !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_valid_clear got %b expected 0", validAt9);
        end
    endtask

    // Negative weights: four times -1 must come through as 32'hFFFFFFFC.
    task automatic test_signed();
        int validCyc;
        hw_sum_t res;
        validCyc = -1; res = '0;
        loadWeights(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        XVec = 4'hF; ResultReady = 1'b1; Start = 1'b1;
        for (int c = 1; c <= 20 && validCyc < 0; c++) begin
            tick();
            Start = 1'b0;
            if (ResultValid) begin validCyc = c; res = Result; end
        end
        checks++;
        if (validCyc != 8 || res !== 32'hFFFFFFFC) begin
            errors++; $display("[TB] FAIL signed_result got %h at cycle %0d expected fffffffc at cycle 8", res, validCyc);
        end
        tick();
    endtask

    // Back-pressure: Result held while Ready is low, Start in HOLD ignored.
    task automatic test_hold();
        logic stableBad, validAt8, valid13, busy13, busy14;
        hw_sum_t res8;
        stableBad = 1'b0; validAt8 = 1'b0; res8 = '0;
        valid13 = 1'b1; busy13 = 1'b1; busy14 = 1'b1;
        loadWeights(8'd3, 8'd5, 8'd7, 8'd2);
        XVec = 4'b1100; ResultReady = 1'b0; Start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) Start = 1'b0;
            if (c == 8) begin validAt8 = ResultValid; res8 = Result; end
            if (c >= 9 && c <= 12 && (Result !== 32'd9 || ResultValid !== 1'b1 || Busy !== 1'b1))
                stableBad = 1'b1;
            if (c == 10) begin Start = 1'b1; XVec = 4'hF; end
            if (c == 11) Start = 1'b0;
            if (c == 12) ResultReady = 1'b1;
            if (c == 13) begin valid13 = ResultValid; busy13 = Busy; end
            if (c == 14) busy14 = Busy;
        end
        checks++;
        if (validAt8 !== 1'b1 || res8 !== 32'd9) begin
            errors++; $display("[TB] FAIL hold_result got valid=%b result=%0d expected valid=1 result=9", validAt8, res8);
        end
        checks++;
        if (stableBad !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_stable got unstable=%b expected 0", stableBad);
        end
        checks++;
        if (valid13 !== 1'b0 || busy13 !== 1'b0 || busy14 !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_release got valid=%b busy=%b,%b expected 0 0,0", valid13, busy13, busy14);
        end
    endtask

    // Abort mid-RUN: clear next cycle, no further strobes, no result.
    task automatic test_abort();
        logic rst5, busy5, get5, anyGetLate, anyValid, anyDone;
        hw_sum_t z6, z14;
        rst5 = 1'b0; busy5 = 1'b1; get5 = 1'b1; anyGetLate = 1'b0; anyValid = 1'b0; anyDone = 1'b0;
        z6 = '1; z14 = '1;
        loadWeights(8'd3, 8'd5, 8'd7, 8'd2);
        XVec = 4'b1011; ResultReady = 1'b1; Start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) Start = 1'b0;
            if (c == 4) Abort = 1'b1;
            if (c == 5) begin rst5 = RstSum; busy5 = Busy; get5 = Get; Abort = 1'b0; end
            if (c >= 5 && Get) anyGetLate = 1'b1;
            if (ResultValid) anyValid = 1'b1;
            if (Done) anyDone = 1'b1;
            if (c == 6) z6 = Z;
            if (c == 14) z14 = Z;
        end
        checks++;
        if (rst5 !== 1'b1 || busy5 !== 1'b0 || get5 !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_cycle5 got rstsum=%b busy=%b get=%b expected 1 0 0", rst5, busy5, get5);
        end
        checks++;
        if (anyGetLate || anyValid || anyDone) begin
            errors++; $display("[TB] FAIL abort_quiet got get=%b valid=%b done=%b expected 0 0 0", anyGetLate, anyValid, anyDone);
        end
        checks++;
        if (z6 !== 32'd0 || z14 !== 32'd0) begin
            errors++; $display("[TB] FAIL abort_sum got %h,%h expected 0,0", z6, z14);
        end
    endtask

    // Asynchronous reset in cycle 3 zeroes every output at once; a fresh run then works.
    task automatic test_rst_mid();
        loadWeights(8'd3, 8'd5, 8'd7, 8'd2);
        XVec = 4'b1011; ResultReady = 1'b1; Start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            Start = 1'b0;
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({WAddr, WRdEn, W, X, ComputeH, Get, RstSum, Result, ResultValid, Busy, Done} !== '0) begin
            errors++;
            $display("[TB] FAIL midrun_reset got Busy=%b WRdEn=%b Get=%b Result=%h expected all 0",
                     Busy, WRdEn, Get, Result);
        end
        #1;
        RST = 1'b0;
        tick();
        test_basic();
    endtask

    // Start held high: second run accepted the cycle after the first handshake.
    task automatic test_back_to_back();
        logic [31:0] getMask, rstMask;
        logic busy9, busy19;
        hw_sum_t res8, res17;
        getMask = '0; rstMask = '0; busy9 = 1'b1; busy19 = 1'b1; res8 = '0; res17 = '0;
        loadWeights(8'd3, 8'd5, 8'd7, 8'd2);
        XVec = 4'b0001; ResultReady = 1'b1; Start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) XVec = 4'b0110;
            if (c == 10) XVec = 4'b0000;
            getMask[c] = Get;
            rstMask[c] = RstSum;
            if (c == 8 && ResultValid) res8 = Result;
            if (c == 9) busy9 = Busy;
            if (c == 17) begin if (ResultValid) res17 = Result; Start = 1'b0; end
            if (c == 19) busy19 = Busy;
        end
        checks++;
        if (res8 !== 32'd3 || res17 !== 32'd12) begin
            errors++; $display("[TB] FAIL b2b_results got %0d,%0d expected 3,12", res8, res17);
        end
        checks++;
        if (rstMask !== 32'h00000402 || getMask !== 32'h0000F078) begin
            errors++; $display("[TB] FAIL b2b_timing got rst=%h get=%h expected 00000402 0000f078", rstMask, getMask);
        end
        checks++;
        if (busy9 !== 1'b0 || busy19 !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_idle got busy9=%b busy19=%b expected 0 0", busy9, busy19);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_hold();
        test_abort();
        test_rst_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hw_sequencer.md
# hw_sequencer

Controller for the hidden-neuron accumulator (weight/input multiply-accumulate with `ComputeH`/`Get`/`RstSum` controls and 32-bit running sum `Z`). On `Start` it latches an N-bit input vector, clears the accumulator, and streams N weights from a synchronous weight memory into the accumulator, one per cycle. It then captures the final sum and holds it behind a valid/ready handshake. It sits between the layer-level scheduler and one accumulator instance.

## Interface
- `N_INPUTS`, 16: inputs per neuron (≥2).
- `W_WIDTH`, 8: weight width; must match the accumulator `w` port.
- `AW`, `$clog2(N_INPUTS)`: weight address width.
- `Clk` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `Start` in 1: begin one neuron evaluation; sampled only in IDLE.
- `Abort` in 1: cancel the evaluation in progress; ignored in IDLE and HOLD.
- `XVec` in N_INPUTS: binary inputs; bit i pairs with weight address i.
- `WAddr` out AW: weight memory read address.
- `WRdEn` out 1: weight memory read enable.
- `WData` in W_WIDTH: read data; valid exactly 1 cycle after `WRdEn`.
- `W` out W_WIDTH: to accumulator `w`.
- `X` out 1: to accumulator `x`.
- `ComputeH`, `Get` out 1 each: accumulate strobes; always driven identically.
- `RstSum` out 1: accumulator clear.
- `Z` in 32: accumulator running sum.
- `Result` out 32: captured neuron sum.
- `ResultValid` out 1: `Result` is valid.
- `ResultReady` in 1: consumer accepts `Result`.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: single-cycle pulse when `Result` is captured.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, CAPTURE, HOLD.
- IDLE, `Start`=1: latch `XVec` into `xReg`, go to CLEAR.
- CLEAR: `RstSum`=1 for 1 cycle, set `idx`=0, go to RUN.
- RUN: `WRdEn`=1 and `WAddr`=`idx` each cycle, then `idx`++. When `idx`==N_INPUTS-1 the read issues and the next state is DRAIN.
- Fetch stage: 1-cycle delayed copies of `WRdEn` and `idx`. Whenever the delayed enable is high:
  - `ComputeH`=`Get`=1;
  - `W`=`WData`;
  - `X`=`xReg[idx_d]`.
- Otherwise `ComputeH`=`Get`=`X`=0 and `W`=0.
- DRAIN: the last accumulate strobe fires here; go to CAPTURE.
- CAPTURE: `Z` is now final. `Result`<=`Z`, `ResultValid`<=1, `Done`=1; go to HOLD.
- HOLD: `Result` and `ResultValid` are stable. `ResultValid`&&`ResultReady` clears `ResultValid` next cycle and returns to IDLE.
- Abort in CLEAR/RUN/DRAIN/CAPTURE:
  - next cycle `RstSum`=1, all strobes=0, the fetch pipe is flushed, state goes to IDLE;
  - no `Result`, no `Done`;
  - Abort wins over a same-cycle CAPTURE capture.
- `RstSum` and `Get` are never high in the same cycle, because the accumulator gives `Get` priority.
- Arithmetic: none inside this block. `Z` passes through unmodified, including 2's-complement wrap and the accumulator's signed 8-bit product.

## Timing
- Reset: state=IDLE, `idx`=0, `xReg`=0, fetch pipe=0. Every output is 0, including `Result`. The accumulator receives the same `RST`.
- Reset mid-operation aborts immediately. No handshake completes, and `ResultValid` drops asynchronously.
- Let `Start` be sampled at cycle 0:
  - cycle 1: `RstSum`;
  - cycles 2..N+1: reads;
  - cycles 3..N+2: `Get`;
  - cycle N+3: CAPTURE;
  - cycle N+4: `ResultValid`=1 and `Done` visible (`Done` registered).
- `Start` outside IDLE is ignored, including in the cycle the HOLD handshake completes. The earliest next `Start` is accepted one cycle after the handshake.
- `XVec` is sampled only at the accepting cycle. Later changes have no effect.

## Structure
- `hw_pkg`: state enum `hw_seq_state_t`, default `N_INPUTS`, `W_WIDTH`, and the 32-bit sum type.
- One sub-module, `hw_fetch_stage`: the 1-cycle delay of `WRdEn`/`idx` with a synchronous flush, producing `Get`, `W` and `X`.
- The accumulator stays external and is connected by the parent.

## Test plan
- N=4, weights {3,5,7,2}, `XVec`=4'b1011, `ResultReady`=1 → `Get` high in cycles 3..6, `ResultValid` in cycle 8, `Result`=10, `Done` pulses once.
- N=4, all weights 8'hFF, `XVec`=4'hF → `Result`=32'hFFFFFFFC (signed pass-through).
- `ResultReady` held low for 5 cycles after valid, with `Start` pulsed during HOLD → `Result` stable, `Start` ignored; valid clears the cycle after Ready=1.
- Abort in cycle 4 (mid-RUN) → `RstSum` high in cycle 5, no further `Get`, IDLE in cycle 5, `ResultValid` never rises, `Z` reads 0 afterwards.
- `RST` pulsed in cycle 3 → all outputs 0 immediately, state IDLE. A fresh `Start` then produces the correct result with full latency.
- Back-to-back runs with `Start` held high continuously → second run accepted exactly one cycle after the first handshake. Its `RstSum` precedes its first `Get`, and `Result` excludes the prior sum.
